// File: rtl/seq_detect_pkg.sv
// Shared types for the sequence-detector sequencer: FSM state names and the
// {A,B} pair layout presented to the detector.
package seq_detect_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_e;

    // a is the upper bit of a pattern pair, b the lower bit
    typedef struct packed {
        logic a;
        logic b;
    } pair_t;

    function automatic logic is_busy(state_e s);
        return (s == CLR) || (s == RUN) || (s == DRAIN);
    endfunction

endpackage

// File: rtl/seq_detect_ctrl_if.sv
// Host/detector bundle of the sequencer; the controller uses the slave modport,
// the host/bench side the master modport.
interface seq_detect_ctrl_if #(
    parameter int SEQ_W = 24,
    parameter int LEN_W = 4,
    parameter int CNT_W = 4
);
    // Handshake: start is a request level sampled only while the controller is
    // idle; busy is high from the cycle after acceptance until done, done is a
    // single-cycle pulse, and there is no backpressure on either side.
    logic                   start;
    logic [SEQ_W-1:0]       cfg_seq;
    logic [LEN_W-1:0]       cfg_len;
    logic                   det_clr;
    logic                   det_a;
    logic                   det_b;
    logic                   det_z;
    logic                   busy;
    logic                   done;
    logic [CNT_W-1:0]       match_cnt;
    logic [LEN_W-1:0]       first_idx;
    logic                   first_vld;
    seq_detect_pkg::state_e dbg_state;

    modport master (
        output start, cfg_seq, cfg_len, det_z,
        input  det_clr, det_a, det_b, busy, done,
               match_cnt, first_idx, first_vld, dbg_state
    );

    modport slave (
        input  start, cfg_seq, cfg_len, det_z,
        output det_clr, det_a, det_b, busy, done,
               match_cnt, first_idx, first_vld, dbg_state
    );

endinterface

// File: rtl/seq_detect_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of
// wrapping.
module sat_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/seq_detect_ctrl.sv
// Sequencer for a 2-bit-per-cycle sequence detector: clears it, streams the
// latched pattern MSB pair first, then tallies Z pulses tied back to run index.
module seq_detect_ctrl
    import seq_detect_pkg::*;
#(
    parameter int SEQ_W   = 24,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 4,
    parameter int DET_LAT = 1
) (
    input logic               clk,
    input logic               clr,
    seq_detect_ctrl_if.slave  bus
);

    localparam int               NPAIR      = SEQ_W / 2;
    localparam logic [LEN_W-1:0] NPAIR_L    = LEN_W'(NPAIR);
    localparam int               DRW        = (DET_LAT > 1) ? $clog2(DET_LAT) : 1;
    localparam logic [DRW-1:0]   DRAIN_LAST = DRW'(DET_LAT - 1);

    state_e           state_q, state_d;
    logic [SEQ_W-1:0] seq_q;
    logic [SEQ_W-1:0] seq_load;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_cl;
    logic [LEN_W:0]   pad_pairs;
    logic [LEN_W-1:0] run_cnt_q;
    logic [DRW-1:0]   drain_cnt_q;
    pair_t            pair_q;
    logic             pipe_vld_q [DET_LAT];
    logic [LEN_W-1:0] pipe_idx_q [DET_LAT];
    logic [LEN_W-1:0] first_idx_q;
    logic             first_vld_q;
    logic             accept;
    logic             z_count;

    assign accept  = (state_q == IDLE) && bus.start;
    assign z_count = pipe_vld_q[DET_LAT-1] && bus.det_z;

    // Left-align the pattern so pair len-1 sits in the top two bits; RUN then
    // only ever shifts left and reads the top pair.
    always_comb begin
        len_cl    = (bus.cfg_len > NPAIR_L) ? NPAIR_L : bus.cfg_len;
        pad_pairs = {1'b0, NPAIR_L} - {1'b0, len_cl};
        seq_load  = bus.cfg_seq << {pad_pairs, 1'b0};
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = CLR;
            CLR:     state_d = (len_q != '0) ? RUN : DONE;
            RUN:     if (run_cnt_q == len_q - LEN_W'(1)) state_d = DRAIN;
            DRAIN:   if (drain_cnt_q == DRAIN_LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.det_clr   = (state_q == CLR);
        bus.busy      = is_busy(state_q);
        bus.done      = (state_q == DONE);
        bus.dbg_state = state_q;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            seq_q       <= '0;
            len_q       <= '0;
            run_cnt_q   <= '0;
            drain_cnt_q <= '0;
            pair_q      <= '0;
        end else begin
            if (accept) begin
                seq_q <= seq_load;
                len_q <= len_cl;
            end else if (state_d == RUN) begin
                seq_q <= seq_q << 2;
            end
            // The pair register is loaded on the edge entering each RUN cycle.
            pair_q      <= (state_d == RUN) ? pair_t'(seq_q[SEQ_W-1 -: 2]) : '0;
            run_cnt_q   <= (state_q == RUN) ? run_cnt_q + LEN_W'(1) : '0;
            drain_cnt_q <= (state_q == DRAIN) ? drain_cnt_q + DRW'(1) : '0;
        end
    end

    // The pipe lines up each Z with the pair sent DET_LAT cycles earlier.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < DET_LAT; i++) begin
                pipe_vld_q[i] <= 1'b0;
                pipe_idx_q[i] <= '0;
            end
        end else begin
            pipe_vld_q[0] <= (state_q == RUN);
            pipe_idx_q[0] <= run_cnt_q;
            for (int i = 1; i < DET_LAT; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_idx_q[i] <= pipe_idx_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            first_idx_q <= '0;
            first_vld_q <= 1'b0;
        end else if (accept) begin
            first_idx_q <= '0;
            first_vld_q <= 1'b0;
        end else if (z_count && !first_vld_q) begin
            first_idx_q <= pipe_idx_q[DET_LAT-1];
            first_vld_q <= 1'b1;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk     (clk),
        .clr     (clr),
        .clear_i (accept),
        .inc_i   (z_count),
        .count_o (bus.match_cnt)
    );

    assign bus.det_a     = pair_q.a;
    assign bus.det_b     = pair_q.b;
    assign bus.first_idx = first_idx_q;
    assign bus.first_vld = first_vld_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: instance A (CNT_W=4) gets directed and random Z
// patterns, instance B (CNT_W=2) shares its stimulus with Z tied high.
module tb_seq_detect_ctrl;
  import seq_detect_pkg::*;

  localparam int SEQ_W   = 24;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 4;
  localparam int DET_LAT = 1;
  localparam int NPAIR   = SEQ_W / 2;
  localparam int A_MAX   = 15;
  localparam int B_MAX   = 3;

  logic clk;
  logic clr;
  int   n_checks;
  int   n_errors;
  logic [1:0] exp_q[$];

  seq_detect_ctrl_if #(.SEQ_W(SEQ_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus_a ();
  seq_detect_ctrl_if #(.SEQ_W(SEQ_W), .LEN_W(LEN_W), .CNT_W(2))     bus_b ();

  assign bus_b.start   = bus_a.start;
  assign bus_b.cfg_seq = bus_a.cfg_seq;
  assign bus_b.cfg_len = bus_a.cfg_len;
  assign bus_b.det_z   = 1'b1;

  seq_detect_ctrl #(.SEQ_W(SEQ_W), .LEN_W(LEN_W), .CNT_W(CNT_W), .DET_LAT(DET_LAT)) dut_a (
    .clk (clk),
    .clr (clr),
    .bus (bus_a)
  );

  seq_detect_ctrl #(.SEQ_W(SEQ_W), .LEN_W(LEN_W), .CNT_W(2), .DET_LAT(DET_LAT)) dut_b (
    .clk (clk),
    .clr (clr),
    .bus (bus_b)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one job from an IDLE negedge; ends on the negedge of the DONE cycle.
  // Z in cycle t (t=0 is CLR) counts when it answers a RUN pair: 1+DET_LAT <= t <= len+DET_LAT.
  task automatic do_run(input logic [23:0] seq, input logic [3:0] len_in,
                        input logic [63:0] zpat, input bit hold);
    int len, last, cnt, fi;
    bit fv;
    logic [1:0] exp_pair;
    len = (int'(len_in) > NPAIR) ? NPAIR : int'(len_in);
    for (int i = len - 1; i >= 0; i--) exp_q.push_back(seq[2*i +: 2]);
    cnt = 0; fi = 0; fv = 1'b0;
    for (int t = 1 + DET_LAT; t <= len + DET_LAT; t++) begin
      if (zpat[t]) begin
        if (!fv) begin fv = 1'b1; fi = t - 1 - DET_LAT; end
        cnt++;
      end
    end
    last = (len == 0) ? 1 : len + DET_LAT + 1;

    bus_a.start   = 1'b1;
    bus_a.cfg_seq = seq;
    bus_a.cfg_len = len_in;
    @(posedge clk); #1;
    if (!hold) bus_a.start = 1'b0;
    bus_a.cfg_seq = 24'($urandom);
    bus_a.cfg_len = 4'($urandom);
    for (int t = 0; t <= last; t++) begin
      bus_a.det_z = zpat[t];
      @(negedge clk);
      exp_pair = 2'b00;
      if (len > 0 && t >= 1 && t <= len && exp_q.size() > 0) exp_pair = exp_q.pop_front();
      check("det_clr", 32'(bus_a.det_clr), 32'(t == 0));
      check("pair", 32'({bus_a.det_a, bus_a.det_b}), 32'(exp_pair));
      check("busy", 32'(bus_a.busy), 32'(t < last));
      check("done", 32'(bus_a.done), 32'(t == last));
      if (t != last) begin @(posedge clk); #1; end
    end
    bus_a.det_z = 1'b0;
    check("match_cnt", 32'(bus_a.match_cnt), 32'((cnt > A_MAX) ? A_MAX : cnt));
    check("first_vld", 32'(bus_a.first_vld), 32'(fv));
    check("first_idx", 32'(bus_a.first_idx), 32'(fi));
    check("sat_cnt", 32'(bus_b.match_cnt), 32'((len > B_MAX) ? B_MAX : len));
    check("sat_first_vld", 32'(bus_b.first_vld), 32'(len > 0));
    check("sat_first_idx", 32'(bus_b.first_idx), 32'(0));
    check("sb_empty", 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    logic [23:0] seqr;
    logic [3:0]  lenr;
    logic [63:0] zr;
    n_checks = 0;
    n_errors = 0;
    clr = 1'b1;
    bus_a.start   = 1'b0;
    bus_a.cfg_seq = '0;
    bus_a.cfg_len = '0;
    bus_a.det_z   = 1'b0;
    #1;
    check("rst_busy", 32'(bus_a.busy), 32'(0));
    check("rst_done", 32'(bus_a.done), 32'(0));
    check("rst_det_clr", 32'(bus_a.det_clr), 32'(0));
    check("rst_cnt", 32'(bus_a.match_cnt), 32'(0));
    check("rst_state", 32'(bus_a.dbg_state), 32'(IDLE));
    repeat (3) @(negedge clk);
    clr = 1'b0;
    @(negedge clk);

    // Known pattern: pairs 01,11,01,11,01,11,00,11,10,00,11,10; Z also outside the window
    do_run(24'b011101110111001110001110, 4'd12, 64'h0000_0000_0000_6109, 1'b0);
    @(negedge clk);

    // Zero length: clear only, straight to DONE
    do_run(24'hABCDEF, 4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    @(negedge clk);

    // Z only in CLR, first RUN cycle and DONE: nothing counted
    do_run(24'h123456, 4'd6, 64'h0000_0000_0000_0103, 1'b0);
    @(negedge clk);

    // Z answering run indices 4 and 5: first_idx stays 4
    do_run(24'h654321, 4'd6, 64'h0000_0000_0000_00C0, 1'b0);
    @(negedge clk);

    // Over-length request clamps to the full pattern
    do_run(24'hF0F0F0, 4'd15, 64'h0000_0000_0000_3FFC, 1'b0);
    @(negedge clk);

    // start held high through the run and DONE: no re-trigger until IDLE
    do_run(24'h5A5A5A, 4'd3, 64'h0000_0000_0000_0004, 1'b1);
    @(negedge clk);
    check("hold_idle_busy", 32'(bus_a.busy), 32'(0));
    check("hold_idle_state", 32'(bus_a.dbg_state), 32'(IDLE));
    do_run(24'hC3C3C3, 4'd2, 64'h0000_0000_0000_0008, 1'b0);
    @(negedge clk);

    for (int r = 0; r < 12; r++) begin
      seqr = 24'($urandom);
      lenr = 4'($urandom_range(0, 15));
      zr   = {$urandom, $urandom};
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_run(seqr, lenr, zr, 1'b0);
      @(negedge clk);
    end

    // Asynchronous clear three cycles into RUN with a nonzero count pending
    bus_a.start   = 1'b1;
    bus_a.cfg_seq = 24'hFFFFFF;
    bus_a.cfg_len = 4'd12;
    @(posedge clk); #1;
    bus_a.start = 1'b0;
    bus_a.det_z = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("pre_rst_busy", 32'(bus_a.busy), 32'(1));
    clr = 1'b1;
    #1;
    check("mid_rst_a", 32'(bus_a.det_a), 32'(0));
    check("mid_rst_b", 32'(bus_a.det_b), 32'(0));
    check("mid_rst_busy", 32'(bus_a.busy), 32'(0));
    check("mid_rst_done", 32'(bus_a.done), 32'(0));
    check("mid_rst_cnt", 32'(bus_a.match_cnt), 32'(0));
    check("mid_rst_fvld", 32'(bus_a.first_vld), 32'(0));
    check("mid_rst_state", 32'(bus_a.dbg_state), 32'(IDLE));
    bus_a.det_z = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    check("post_rst_busy", 32'(bus_a.busy), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
